matvec_int8_mlane: RTL and testbench
====================================

// Module: matvec_int8_mlane
// PURPOSE
// - Multi-lane INT8 matrix-vector engine: out[r] = sat8((sum_c W[r][c]*in[c]) >>> shift).
// - Computes LANES output rows per pass, with one wide weight word per column.
// - Weights come from an external synchronous BRAM with configurable read latency.
// - Serves the per-block attention/MLP projections.
// PARAMETERS
// - IN_DIM   128  input vector length (elements, int8)
// - OUT_DIM  128  output vector length; must be a multiple of LANES
// - LANES    4    rows computed in parallel; G = OUT_DIM/LANES row groups
// - ACC_W    24   accumulator width; must be >= 16+clog2(IN_DIM)
// - RD_LAT   1    weight read latency in cycles (0 = combinational read)
// - ADDR_W   clog2(G*IN_DIM)  weight address width (derived)
// PORTS
// - clk          in   1           clock, all state on rising edge
// - rst_n        in   1           synchronous reset, active low
// - start        in   1           request a run; sampled only when idle
// - shift        in   5           requant right shift, 0..ACC_W-1; latched at start
// - in_vec       in   IN_DIM*8    element c = in_vec[c*8+:8], signed; hold stable while busy
// - weight_addr  out  ADDR_W      registered; = g*IN_DIM + c
// - weight_data  in   LANES*8     lane l = W[g*LANES+l][c], signed; valid RD_LAT cycles after the address
// - out_vec      out  OUT_DIM*8   element r = out_vec[r*8+:8], signed
// - busy         out  1           high from the start-accept edge until done
// - done         out  1           one-cycle pulse at run completion
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, out_vec=0, weight_addr=0, accumulators=0.
// - Reset mid-run aborts the run with no done pulse and clears out_vec.
// - States: IDLE -> RUN (issue addresses; accumulate) -> IDLE. E0 is the edge that accepts start.
// - Timing, period P = IN_DIM+RD_LAT+1, group g, column c:
//   - address for (g,c) is registered at edge E(g*P+c);
//   - its data is sampled and MAC'd at edge E(g*P+c+1+RD_LAT);
//   - cycles between a group's last address and the next group's first address issue no new address; weight_addr holds.
// - Group g writeback at edge E((g+1)*P):
//   - out rows g*LANES..g*LANES+LANES-1 are written;
//   - the accumulators clear;
//   - group g+1 column 0 is issued on the same edge.
// - Final writeback at edge E(G*P): done=1 and busy=0 on that edge; done clears on the next edge.
// - Default run: G=32, P=130, done set at edge E(4160).
// - Arithmetic:
//   - products are 16-bit signed, summed into ACC_W-bit signed accumulators;
//   - arithmetic right shift, then saturate to [-128,127].
// - out_vec updates one group at a time during a run; it is valid only while busy=0 and holds between runs.
// - start while busy: ignored (no restart, no queue).
// - start in the done cycle: accepted (the FSM is already IDLE).
// - shift is sampled only at E0; changes mid-run have no effect.
// CONFIGURATION
// - MATVEC_ROUND_EN defined: if shift>0, add 2^(shift-1) to the accumulator before the shift (round half up).
// - MATVEC_ROUND_EN undefined: plain arithmetic shift (floor).
// - The macro changes only the arithmetic; ports and timing are identical in both builds.
// TESTING
// - IN=8, OUT=8, LANES=4, RD_LAT=1, in=all 1, W=all 1, shift=0 -> every out=8; done pulse at E20 only; busy high E0..E19.
// - Saturation (defaults), shift=0:
//   - in=127, W=127 -> all out=127;
//   - in=127, W=-128 -> all out=-128.
// - Shift/round, IN=8, shift=4:
//   - W=3, in=1 -> floor build 1, ROUND_EN build 2;
//   - W=-3, in=1 -> floor build -2, ROUND_EN build -1.
// - Lane order, IN=8, OUT=8: in[0]=1 and others 0, W[r][0]=r -> out[r]=r for r=0..7; weight_addr sequence 0..7, then 8..15.
// - Reset/abort/busy (defaults):
//   - rst_n=0 at E50 -> busy=0, out_vec=0, no done;
//   - a second start pulse during a run is ignored; done timing is unchanged.
// - RD_LAT=0 and RD_LAT=2 with random int8 data -> results match the golden model; done at E(G*(IN_DIM+RD_LAT+1)).

Source files
------------

// File: rtl/matvec_int8_mlane.sv
// ---------------------------------------------------------------------------
// matvec_int8_mlane
// Multi-lane INT8 matrix-vector engine:
//   out[r] = sat8((sum_c W[r][c] * in[c]) >>> shift)
// LANES output rows are computed per pass (one row group); each column of a
// group is one wide weight word fetched from an external synchronous BRAM
// with RD_LAT cycles of read latency.
//
// Optional build macro: MATVEC_ROUND_EN
//   defined   -> round half up before the shift (adds 2^(shift-1) if shift>0)
//   undefined -> plain arithmetic shift (floor)
//
// Ports
//   clk, rst_n   clock (rising edge) and synchronous active-low reset
//   start        run request, sampled only while idle
//   shift        requant right shift, latched when start is accepted
//   in_vec       IN_DIM signed int8 elements, element c at [c*8+:8]
//   weight_addr  registered BRAM address, g*IN_DIM + c
//   weight_data  LANES signed int8 weights, lane l = W[g*LANES+l][c]
//   out_vec      OUT_DIM signed int8 results, element r at [r*8+:8]
//   busy         high from start acceptance until completion
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module matvec_int8_mlane #(
  parameter int unsigned IN_DIM  = 128,
  parameter int unsigned OUT_DIM = 128,
  parameter int unsigned LANES   = 4,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ADDR_W  = $clog2((OUT_DIM / LANES) * IN_DIM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4:0]           shift,
  input  logic [IN_DIM*8-1:0]  in_vec,
  output logic [ADDR_W-1:0]    weight_addr,
  input  logic [LANES*8-1:0]   weight_data,
  output logic [OUT_DIM*8-1:0] out_vec,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned G     = OUT_DIM / LANES;
  localparam int unsigned P     = IN_DIM + RD_LAT + 1;
  localparam int unsigned CNT_W = $clog2(P);
  localparam int unsigned GRP_W = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned COL_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned ROW_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(IN_DIM - 1);
  localparam logic [CNT_W-1:0] MAC_FIRST  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] COL_LIMIT  = CNT_W'(IN_DIM);
  localparam logic [GRP_W-1:0] GRP_LAST   = GRP_W'(G - 1);

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [GRP_W-1:0]            grp_q, grp_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [4:0]                  shift_q, shift_d;
  logic [LANES-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [OUT_DIM-1:0][7:0]     out_q, out_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [IN_DIM-1:0][7:0]      in_arr;
  logic [LANES-1:0][7:0]       wd_arr;
  logic [LANES-1:0][15:0]      prod;
  logic [CNT_W-1:0]            col_full;
  logic [COL_W-1:0]            col;
  logic                        grp_end;
  logic                        last_grp;
  logic                        mac_en;

  assign in_arr = in_vec;
  assign wd_arr = weight_data;

  // Column being accumulated this cycle. Before the first data arrives the
  // subtraction wraps to a value >= IN_DIM, so one compare covers both ends.
  assign col_full = cnt_q - MAC_FIRST;
  assign mac_en   = (col_full < COL_LIMIT);
  assign col      = COL_W'(col_full);
  assign grp_end  = (cnt_q == CNT_LAST);
  assign last_grp = (grp_q == GRP_LAST);

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    sext8 = $signed({{8{v[7]}}, v});
  endfunction

  // Shift (optionally rounded) and saturate one accumulator to int8.
  function automatic logic [7:0] requant(input logic [ACC_W-1:0] acc,
                                         input logic [4:0]       sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shv;
    logic [7:0]            res;
    ext = $signed({acc[ACC_W-1], acc});
`ifdef MATVEC_ROUND_EN
    if (sh != 5'd0) ext = ext + ((ACC_W+1)'(1) <<< (sh - 5'd1));
`else
    ext = ext;
`endif
    shv = ext >>> sh;
    if (shv > SAT_HI)      res = 8'h7f;
    else if (shv < SAT_LO) res = 8'h80;
    else                   res = shv[7:0];
    requant = res;
  endfunction

  // Per-lane 8x8 signed products for the current column.
  always_comb begin
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = sext8(wd_arr[l]) * sext8(in_arr[col]);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (grp_end && last_grp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          grp_d   = '0;
          addr_d  = '0;
          shift_d = shift;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (grp_end) begin
          // Group writeback; next group's column 0 goes out on this edge.
          for (int l = 0; l < LANES; l++) begin
            out_d[ROW_W'(int'(grp_q) * int'(LANES) + l)] = requant(acc_q[l], shift_q);
          end
          acc_d = '0;
          cnt_d = '0;
          if (last_grp) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            grp_d  = grp_q + GRP_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Addresses stop after the last column; weight_addr holds in the gap.
          if (cnt_q < ISSUE_LAST) addr_d = addr_q + ADDR_W'(1);
          if (mac_en) begin
            for (int l = 0; l < LANES; l++) begin
              acc_d[l] = acc_q[l] + {{(ACC_W-16){prod[l][15]}}, prod[l]};
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      grp_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign weight_addr = addr_q;
  assign out_vec     = out_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_matvec_int8_mlane.sv
module tb_matvec_int8_mlane;

  logic clk;
  logic rst_n;
  logic start;
  logic [4:0] shift;
  int sel;

  int checks;
  int failures;

  logic signed [7:0] wmat [128][128];
  logic signed [7:0] ivec [128];

  // dut_a: defaults, dut_b: IN=8/OUT=8, dut_c: IN=16 RD_LAT=0, dut_d: IN=16 RD_LAT=2
  logic start_a, start_b, start_c, start_d;
  logic [1023:0] in_a;
  logic [63:0]   in_b;
  logic [127:0]  in_cd;
  logic [11:0] addr_a;
  logic [3:0]  addr_b;
  logic [4:0]  addr_c, addr_d;
  logic [31:0] wd0_a, wd0_b, wd0_c, wd0_d;
  logic [31:0] wd_a, wd_b, wd_d1, wd_d;
  logic [1023:0] out_a;
  logic [63:0]   out_b, out_c, out_d;
  logic busy_a, busy_b, busy_c, busy_d;
  logic done_a, done_b, done_c, done_d;

  logic [1023:0] out_s;
  logic busy_s, done_s;
  int addr_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign start_d = start && (sel == 3);

  always_comb begin
    in_a = '0; in_b = '0; in_cd = '0;
    for (int c = 0; c < 128; c++) in_a[c*8+:8] = ivec[c];
    for (int c = 0; c < 8; c++) in_b[c*8+:8] = ivec[c];
    for (int c = 0; c < 16; c++) in_cd[c*8+:8] = ivec[c];
  end

  // BRAM model: word at g*IN+c holds W[g*4+l][c] in lane l.
  always_comb begin
    wd0_a = '0; wd0_b = '0; wd0_c = '0; wd0_d = '0;
    for (int l = 0; l < 4; l++) begin
      wd0_a[l*8+:8] = wmat[(int'(addr_a) / 128) * 4 + l][int'(addr_a) % 128];
      wd0_b[l*8+:8] = wmat[(int'(addr_b) / 8) * 4 + l][int'(addr_b) % 8];
      wd0_c[l*8+:8] = wmat[(int'(addr_c) / 16) * 4 + l][int'(addr_c) % 16];
      wd0_d[l*8+:8] = wmat[(int'(addr_d) / 16) * 4 + l][int'(addr_d) % 16];
    end
  end

  always_ff @(posedge clk) begin
    wd_a  <= wd0_a;
    wd_b  <= wd0_b;
    wd_d1 <= wd0_d;
    wd_d  <= wd_d1;
  end

  matvec_int8_mlane #(.IN_DIM(128), .OUT_DIM(128), .LANES(4), .ACC_W(24), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .shift(shift), .in_vec(in_a),
    .weight_addr(addr_a), .weight_data(wd_a), .out_vec(out_a), .busy(busy_a), .done(done_a));

  matvec_int8_mlane #(.IN_DIM(8), .OUT_DIM(8), .LANES(4), .ACC_W(24), .RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .shift(shift), .in_vec(in_b),
    .weight_addr(addr_b), .weight_data(wd_b), .out_vec(out_b), .busy(busy_b), .done(done_b));

  matvec_int8_mlane #(.IN_DIM(16), .OUT_DIM(8), .LANES(4), .ACC_W(24), .RD_LAT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .shift(shift), .in_vec(in_cd),
    .weight_addr(addr_c), .weight_data(wd0_c), .out_vec(out_c), .busy(busy_c), .done(done_c));

  matvec_int8_mlane #(.IN_DIM(16), .OUT_DIM(8), .LANES(4), .ACC_W(24), .RD_LAT(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .shift(shift), .in_vec(in_cd),
    .weight_addr(addr_d), .weight_data(wd_d), .out_vec(out_d), .busy(busy_d), .done(done_d));

  always_comb begin
    out_s = '0; busy_s = 1'b0; done_s = 1'b0; addr_s = 0;
    case (sel)
      0: begin out_s = out_a; busy_s = busy_a; done_s = done_a; addr_s = int'(addr_a); end
      1: begin out_s[63:0] = out_b; busy_s = busy_b; done_s = done_b; addr_s = int'(addr_b); end
      2: begin out_s[63:0] = out_c; busy_s = busy_c; done_s = done_c; addr_s = int'(addr_c); end
      default: begin out_s[63:0] = out_d; busy_s = busy_d; done_s = done_d; addr_s = int'(addr_d); end
    endcase
  end

  // Reference: exact integer dot product, then floor/round shift and saturate.
  function automatic logic [7:0] golden(input int r, input int in_dim, input int sh);
    longint s;
    s = 0;
    for (int c = 0; c < in_dim; c++) s += longint'(wmat[r][c]) * longint'(ivec[c]);
`ifdef MATVEC_ROUND_EN
    if (sh > 0) s += longint'(1) << (sh - 1);
`endif
    s = s >>> sh;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic fill_uniform(input int w, input int x);
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) wmat[r][c] = 8'(w);
    for (int c = 0; c < 128; c++) ivec[c] = 8'(x);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) wmat[r][c] = 8'($urandom);
    for (int c = 0; c < 128; c++) ivec[c] = 8'($urandom);
  endtask

  // One run: start timing, busy, address sequence, done timing, results.
  task automatic run_check(input int s, input int in_dim, input int out_dim, input int rd_lat,
                           input int sh, input int pulse_at, input bit pre, input bit chain,
                           input string name);
    int p, total, done_k, addr_bad, busy_bad, bad_k, bad_got, bad_exp, ea, g, c;
    logic [7:0] exp_o, got_o;
    p = in_dim + rd_lat + 1;
    total = (out_dim / 4) * p;
    sel = s;
    shift = 5'(sh);
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    shift = 5'($urandom);
    checks++;
    if (busy_s !== 1'b1 || done_s !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept: busy=%0b done=%0b expected busy=1 done=0", name, busy_s, done_s);
    end
    done_k = -1; addr_bad = 0; busy_bad = 0; bad_k = 0; bad_got = 0; bad_exp = 0;
    for (int k = 0; k <= total + 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        if (pulse_at > 0 && k == pulse_at) start = 1'b1;
        if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
      end
      if (k >= total) ea = (out_dim / 4) * in_dim - 1;
      else begin
        g = k / p;
        c = k % p;
        ea = g * in_dim + ((c < in_dim) ? c : in_dim - 1);
      end
      if (addr_s != ea) begin
        if (addr_bad == 0) begin bad_k = k; bad_got = addr_s; bad_exp = ea; end
        addr_bad++;
      end
      if (done_s === 1'b1) begin
        done_k = k;
        break;
      end
      if (busy_s !== 1'b1) busy_bad++;
    end
    checks++;
    if (done_k != total) begin
      failures++;
      $display("FAIL %s_done_edge: done seen at E%0d expected E%0d", name, done_k, total);
    end
    checks++;
    if (busy_bad != 0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy: low_while_running=%0d busy_at_done=%0b expected 0 and 0", name, busy_bad, busy_s);
    end
    checks++;
    if (addr_bad != 0) begin
      failures++;
      $display("FAIL %s_addr: %0d wrong, first at E%0d got %0d expected %0d", name, addr_bad, bad_k, bad_got, bad_exp);
    end
    for (int r = 0; r < out_dim; r++) begin
      exp_o = golden(r, in_dim, sh);
      got_o = out_s[r*8+:8];
      checks++;
      if (got_o !== exp_o) begin
        failures++;
        $display("FAIL %s_out[%0d]: got %0d expected %0d", name, r, $signed(got_o), $signed(exp_o));
      end
    end
    if (chain) begin
      start = 1'b1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_s !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_pulse: done=%0b one edge later, expected 0", name, done_s);
      end
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checks++;
      if (busy_s !== 1'b0 || done_s !== 1'b0 || out_s !== '0 || addr_s != 0) begin
        failures++;
        $display("FAIL reset_state[%0d]: busy=%0b done=%0b addr=%0d out_nonzero=%0b expected all 0",
                 s, busy_s, done_s, addr_s, (out_s != '0));
      end
    end
  endtask

  task automatic test_basic();
    fill_uniform(1, 1);
    run_check(1, 8, 8, 1, 0, 0, 1'b0, 1'b0, "basic");
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_s[r*8+:8] !== 8'd8) begin
        failures++;
        $display("FAIL basic_const[%0d]: got %0d expected 8", r, out_s[r*8+:8]);
      end
    end
  endtask

  task automatic test_shift_round();
    logic [7:0] e_pos, e_neg;
`ifdef MATVEC_ROUND_EN
    e_pos = 8'd2; e_neg = 8'hff;
`else
    e_pos = 8'd1; e_neg = 8'hfe;
`endif
    fill_uniform(3, 1);
    run_check(1, 8, 8, 1, 4, 0, 1'b0, 1'b0, "round_pos");
    checks++;
    if (out_s[7:0] !== e_pos) begin
      failures++;
      $display("FAIL round_pos_const: got %0d expected %0d", $signed(out_s[7:0]), $signed(e_pos));
    end
    fill_uniform(-3, 1);
    run_check(1, 8, 8, 1, 4, 0, 1'b0, 1'b0, "round_neg");
    checks++;
    if (out_s[7:0] !== e_neg) begin
      failures++;
      $display("FAIL round_neg_const: got %0d expected %0d", $signed(out_s[7:0]), $signed(e_neg));
    end
  endtask

  task automatic test_lane_order();
    fill_uniform(0, 0);
    ivec[0] = 8'sd1;
    for (int r = 0; r < 8; r++) wmat[r][0] = 8'(r);
    run_check(1, 8, 8, 1, 0, 0, 1'b0, 1'b0, "lane");
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_s[r*8+:8] !== 8'(r)) begin
        failures++;
        $display("FAIL lane_const[%0d]: got %0d expected %0d", r, out_s[r*8+:8], r);
      end
    end
  endtask

  task automatic test_saturation();
    fill_uniform(127, 127);
    run_check(0, 128, 128, 1, 0, 0, 1'b0, 1'b0, "sat_pos");
    checks++;
    if (out_s[127*8+:8] !== 8'h7f) begin
      failures++;
      $display("FAIL sat_pos_const: got %0d expected 127", $signed(out_s[127*8+:8]));
    end
    fill_uniform(-128, 127);
    run_check(0, 128, 128, 1, 0, 0, 1'b0, 1'b0, "sat_neg");
    checks++;
    if (out_s[0+:8] !== 8'h80) begin
      failures++;
      $display("FAIL sat_neg_const: got %0d expected -128", $signed(out_s[0+:8]));
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_check(0, 128, 128, 1, int'($urandom_range(13, 9)), 1000, 1'b0, 1'b0, "restart_ignored");
  endtask

  task automatic test_reset_abort();
    int bad;
    fill_uniform(127, 127);
    sel = 0;
    shift = 5'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0 || out_s !== '0 || addr_s != 0) begin
      failures++;
      $display("FAIL abort_state: busy=%0b done=%0b addr=%0d out_nonzero=%0b expected all 0",
               busy_s, done_s, addr_s, (out_s != '0));
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_s !== 1'b0 || busy_s !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_check(1, 8, 8, 1, 3, 0, 1'b0, 1'b1, "b2b_first");
    fill_random();
    run_check(1, 8, 8, 1, 5, 0, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_rd_lat();
    for (int it = 0; it < 3; it++) begin
      fill_random();
      run_check(2, 16, 8, 0, int'($urandom_range(10, 4)), 0, 1'b0, 1'b0, "rdlat0");
      fill_random();
      run_check(3, 16, 8, 2, int'($urandom_range(10, 4)), 0, 1'b0, 1'b0, "rdlat2");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    shift = 5'd0;
    sel = 0;
    fill_uniform(0, 0);
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_shift_round();
    test_lane_order();
    test_back_to_back();
    test_rd_lat();
    test_saturation();
    test_start_ignored();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
